// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Purpose : one requester port of the RAM arbiter. A master raises req with
//           we/addr/wdata and holds it until a one-cycle ack comes back. For
//           reads, rdata is valid with ack.
// Signals : req   - access request, held high until ack
//           we    - 1 = write, 0 = read
//           addr  - access address (ADDR_WIDTH)
//           wdata - write data (DATA_WIDTH)
//           ack   - one-cycle completion pulse
//           rdata - registered read data, held until the next read on this port
// Modports: master - the requester (CPU, loader, debug port)
//           slave  - the arbiter side
interface ram_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  ack;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Purpose : shares a single-port RAM between two masters (p0 = CPU, p1 = loader
//           or debug port). Each access runs IDLE -> SETUP -> STROBE -> ACK, so
//           one access completes every 4 cycles. Arbitration happens only in
//           IDLE. The winner's we/addr/wdata are latched at that point, and
//           later changes on the requester inputs are ignored until the next
//           arbitration.
// Ports   : clk       - system clock, all state on the rising edge
//           reset     - asynchronous, active-low reset
//           p0, p1    - requester ports (ram_arbiter_if.slave)
//           ram_addr  - RAM address, registered, held in IDLE
//           ram_wdata - RAM write data, registered, held in IDLE
//           ram_we    - RAM write strobe, high only during STROBE of a write
//           ram_oe    - RAM read enable, high only during STROBE of a read
//           ram_rdata - RAM read data, valid while ram_oe is high
//           busy      - high in every state except IDLE
//           grant_id  - port owning the current or most recent transaction
// Config  : RAM_ARB_FIXED_PRIO_EN - when defined, port 0 always wins
//           contention. Otherwise (the default) contention is round-robin
//           using last_grant.
module ram_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   ram_arbiter_if.slave          p0,
   ram_arbiter_if.slave          p1,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_we,
   output logic                  ram_oe,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  busy,
   output logic                  grant_id
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      ACK    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  ram_we_q, ram_we_d;
   logic                  ram_oe_q, ram_oe_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic                  p0_ack_q, p0_ack_d;
   logic                  p1_ack_q, p1_ack_d;
   logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
   logic                  winner;

   // Winner of the current IDLE cycle. The value only matters when at least
   // one req is high.
   always_comb begin
      winner = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
      winner = ~p0.req;
`else
      // Under contention the port that did not win last time goes next.
      if (p0.req && p1.req) begin
         winner = ~last_grant_q;
      end else begin
         winner = p1.req;
      end
`endif
   end

   // Next-state and output decode. The strobes and the ack are computed one
   // state early so that they come straight from flops during STROBE and ACK.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      ram_we_d     = 1'b0;
      ram_oe_d     = 1'b0;
      p0_ack_d     = 1'b0;
      p1_ack_d     = 1'b0;
      p0_rdata_d   = p0_rdata_q;
      p1_rdata_d   = p1_rdata_q;

      case (state_q)
         IDLE: begin
            if (p0.req || p1.req) begin
               state_d      = SETUP;
               grant_d      = winner;
               last_grant_d = winner;
               if (winner) begin
                  we_d    = p1.we;
                  addr_d  = p1.addr;
                  wdata_d = p1.wdata;
               end else begin
                  we_d    = p0.we;
                  addr_d  = p0.addr;
                  wdata_d = p0.wdata;
               end
            end
         end
         SETUP: begin
            state_d  = STROBE;
            ram_we_d = we_q;
            ram_oe_d = ~we_q;
         end
         STROBE: begin
            state_d = ACK;
            // ram_oe is high during this cycle, so ram_rdata is valid at the
            // closing edge.
            if (grant_q) begin
               p1_ack_d = 1'b1;
               if (!we_q) begin
                  p1_rdata_d = ram_rdata;
               end
            end else begin
               p0_ack_d = 1'b1;
               if (!we_q) begin
                  p0_rdata_d = ram_rdata;
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // last_grant resets to 1 so that port 0 wins the first contention.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ram_we_q     <= 1'b0;
         ram_oe_q     <= 1'b0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         p0_ack_q     <= 1'b0;
         p1_ack_q     <= 1'b0;
         p0_rdata_q   <= '0;
         p1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ram_we_q     <= ram_we_d;
         ram_oe_q     <= ram_oe_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         p0_ack_q     <= p0_ack_d;
         p1_ack_q     <= p1_ack_d;
         p0_rdata_q   <= p0_rdata_d;
         p1_rdata_q   <= p1_rdata_d;
      end
   end

   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign ram_we    = ram_we_q;
   assign ram_oe    = ram_oe_q;
   assign busy      = (state_q != IDLE);
   assign grant_id  = grant_q;
   assign p0.ack    = p0_ack_q;
   assign p1.ack    = p1_ack_q;
   assign p0.rdata  = p0_rdata_q;
   assign p1.rdata  = p1_rdata_q;

endmodule
